par_ser_conv_32: RTL
====================

Name: par_ser_conv_32

Overview:
Parallel-to-serial transmitter. It is the counterpart of the serial-to-parallel converter on the FIFO write side.
- Drains 32-bit words from the read port of the dual-port FIFO, in the FIFO's read-clock domain.
- Shifts each word out LSB-first on a 1-bit line, qualified by an enable strobe.
- Its framing and bit order match what the receiver's shift register (new bit into MSB, shift right) expects.
- Back-to-back words are sent with no idle gap when the FIFO holds data.

Parameters:
- word_width, 32, bits per word and shift-register width.
- cntr_width, 5, bit-counter width; must satisfy 2**cntr_width >= word_width.

Ports:
- clk  input  1  single clock, equal to the FIFO read clock.
- rst  input  1  reset; synchronous, active-high.
- Data_in  input  word_width  FIFO Data_out; valid the cycle after read is asserted.
- empty  input  1  FIFO stk_empty.
- hold  input  1  downstream back-pressure; sampled only at word boundaries.
- read  output  1  FIFO read request, one-cycle pulse per word.
- Data_out  output  1  serial data, LSB first.
- En_out  output  1  high while Data_out carries a valid bit.
- word_done  output  1  pulse during the cycle the last bit (bit word_width-1) is on the line.
- busy  output  1  high in any state other than S_IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=S_IDLE, shift register=0, cntr=0.
  - All outputs are 0 from the next cycle, and rst overrides every other condition.
  - If a fetch is in flight, the word already popped from the FIFO is discarded and is not retransmitted.
- States: S_IDLE, S_FETCH, S_SHIFT; 2-bit state register.
- S_IDLE:
  - read is combinational: read = !empty && !hold.
  - If read=1 the next state is S_FETCH; otherwise stay in S_IDLE.
- S_FETCH:
  - FIFO data is valid on Data_in during this cycle.
  - At the posedge: load the shift register with Data_in, set cntr=0, go to S_SHIFT.
  - read=0 and En_out=0 in this state.
- S_SHIFT, outputs:
  - Data_out = shift register bit 0.
  - En_out = 1.
  - At each posedge the register shifts right with 0 fill and cntr increments.
- S_SHIFT, pipelined prefetch:
  - When cntr == word_width-2, read = !empty && !hold, evaluated that cycle.
  - This early read makes the next word's Data_in valid during the cycle cntr == word_width-1.
- S_SHIFT, last bit (cntr == word_width-1):
  - word_done=1.
  - If a prefetch was issued (registered flag pf): load Data_in, cntr=0, stay in S_SHIFT. This gives zero gap; En_out stays high across the boundary.
  - If no prefetch: go to S_IDLE and clear cntr. En_out drops the following cycle.
- Latency:
  - From S_IDLE: read in cycle t, bit 0 on Data_out in cycle t+2.
  - One word occupies exactly word_width consecutive En_out cycles.
- hold behaviour:
  - hold never interrupts a word already in progress.
  - hold=1 at the prefetch cycle suppresses the prefetch, so the block returns to S_IDLE after the current word.
- empty=1 at the prefetch cycle: no prefetch; return to S_IDLE after the current word. A word arriving later starts from S_IDLE.
- read is never asserted while empty=1, and at most one read is issued per word.
- cntr wraps only by explicit clear; it never reaches word_width.
- Unused encoding of the state register forces S_IDLE with all outputs 0.

Decomposition:
- Shared package holds:
  - state encodings S_IDLE=0, S_FETCH=1, S_SHIFT=2;
  - default word_width=32 and cntr_width=5.
- One sub-module is natural: par_ser_datapath, containing the shift register, cntr and the cntr_limit/prefetch compare flags.
- The top holds the control FSM and the read/pf logic, mirroring the Control_Unit/Datapath_Unit split on the receive side.

Test Plan:
- Single word:
  - Stimulus: FIFO holds 32'hA5A5_0F0F, hold=0.
  - Required: read pulses once; 2 cycles later, 32 cycles of En_out=1.
  - Required: Data_out sequence is bit 0 first, i.e. 1,1,1,1,0,0,0,0,...; word_done is high on cycle 32; then En_out=0 and busy=0.
- Back-to-back:
  - Stimulus: FIFO holds 32'h0000_0001 and 32'h8000_0000.
  - Required: 64 contiguous En_out cycles; Data_out=1 on cycle 1 and on cycle 64, 0 elsewhere.
  - Required: read asserted on cycle 31 of word 1; exactly 2 reads in total.
- Empty at prefetch:
  - Stimulus: one word, then a second word written after the prefetch cycle has passed.
  - Required: En_out drops after bit 31; the second word begins via S_IDLE with a gap of 2 cycles.
- hold:
  - Stimulus: hold=1 in S_IDLE with FIFO non-empty.
  - Required: read=0 and busy=0 indefinitely; releasing hold produces read on the same cycle.
  - Stimulus: hold asserted mid-word.
  - Required: the word completes; no prefetch is issued.
- Reset mid-word:
  - Stimulus: rst=1 at bit 10 of a word.
  - Required: the next cycle Data_out=0, En_out=0, busy=0; after rst drops, the next FIFO word transmits from bit 0 correctly.
- Loopback:
  - Stimulus: connect Data_out/En_out to the serial-to-parallel receiver; send 16 random words.
  - Required: the receiver writes identical words in order.

Source files
------------

// File: rtl/par_ser_conv_32_pkg.sv
// rtl/par_ser_conv_32_pkg.sv - shared state encodings and default widths for the serial transmitter
package par_ser_conv_32_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_CNTR_WIDTH = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/par_ser_datapath.sv
// rtl/par_ser_datapath.sv - shift register, bit counter and word-position compare flags
module par_ser_datapath
    import par_ser_conv_32_pkg::*;
#(
    parameter int word_width = DEF_WORD_WIDTH,
    parameter int cntr_width = DEF_CNTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  clr,
    input  logic [word_width-1:0] data_in,
    output logic                  bit0,
    output logic                  cntr_limit,
    output logic                  pf_point
);

    localparam logic [cntr_width-1:0] LAST_BIT = cntr_width'(word_width - 1);
    localparam logic [cntr_width-1:0] PF_BIT   = cntr_width'(word_width - 2);

    logic [word_width-1:0] sr_q, sr_d;
    logic [cntr_width-1:0] cntr_q, cntr_d;

    always_comb begin
        sr_d   = sr_q;
        cntr_d = cntr_q;
        if (load) begin
            sr_d   = data_in;
            cntr_d = '0;
        end else if (shift) begin
            sr_d   = sr_q >> 1;
            cntr_d = cntr_q + cntr_width'(1);
        end else if (clr) begin
            cntr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cntr_q <= '0;
        end else begin
            sr_q   <= sr_d;
            cntr_q <= cntr_d;
        end
    end

    assign bit0       = sr_q[0];
    assign cntr_limit = (cntr_q == LAST_BIT);
    assign pf_point   = (cntr_q == PF_BIT);

endmodule

// File: rtl/par_ser_conv_32.sv
// rtl/par_ser_conv_32.sv - FIFO-draining parallel-to-serial transmitter, LSB first, gapless back-to-back words
module par_ser_conv_32
    import par_ser_conv_32_pkg::*;
#(
    parameter int word_width = DEF_WORD_WIDTH,
    parameter int cntr_width = DEF_CNTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] Data_in,
    input  logic                  empty,
    input  logic                  hold,
    output logic                  read,
    output logic                  Data_out,
    output logic                  En_out,
    output logic                  word_done,
    output logic                  busy
);

    state_t state_q, state_d;
    logic   pf_q, pf_d;
    logic   load, shift, clr;
    logic   sr_bit0, cntr_limit, pf_point;
    logic   can_read;

    // Gating with rst keeps a reset cycle from popping a word that would then be lost.
    assign can_read = !empty && !hold && !rst;

    always_comb begin
        state_d   = state_q;
        pf_d      = pf_q;
        read      = 1'b0;
        Data_out  = 1'b0;
        En_out    = 1'b0;
        word_done = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        clr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                pf_d = 1'b0;
                read = can_read;
                if (can_read) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                load    = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy     = 1'b1;
                En_out   = 1'b1;
                Data_out = sr_bit0;
                if (pf_point) begin
                    read = can_read;
                    pf_d = can_read;
                end
                if (cntr_limit) begin
                    word_done = 1'b1;
                    pf_d      = 1'b0;
                    if (pf_q) begin
                        load = 1'b1;
                    end else begin
                        clr     = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    shift = 1'b1;
                end
            end
            default: begin
                pf_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pf_q    <= pf_d;
        end
    end

    par_ser_datapath #(
        .word_width(word_width),
        .cntr_width(cntr_width)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .clr       (clr),
        .data_in   (Data_in),
        .bit0      (sr_bit0),
        .cntr_limit(cntr_limit),
        .pf_point  (pf_point)
    );

endmodule
